// File: rtl/scoreboard_display_sequencer.sv
// Scoreboard display sequencer.
// Time-multiplexes the scores of NUM_PLAYERS players onto one two-digit
// display. For each enabled player the tag "P<n>" blinks, then the score is
// held, then the rotation moves to the next enabled player.
//
// Ports:
//   clk_1khz      1 kHz tick clock
//   rst_i         synchronous active-high reset
//   tens_i/ones_i packed score digits, player k at [4k+3:4k]
//   enable_i      per-player rotation enable mask
//   hold_i        freezes timer and sequence while high
//   sel_valid_i   one-cycle jump request to sel_player_i
//   tens_o/ones_o digit codes to the decoders (10 = blank, 11 = 'P')
//   player_o      current player index
//   blinking_o    high while the tag is blinking
module scoreboard_display_sequencer #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BLINK_MS        = 500,
  parameter int DISPLAY_MS      = 2000,
  parameter int BLINK_ON_PHASES = 3,
  localparam int PW   = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int TMAX = (BLINK_MS > DISPLAY_MS) ? BLINK_MS : DISPLAY_MS,
  localparam int TW   = $clog2(TMAX + 1)
) (
  input  logic                     clk_1khz,
  input  logic                     rst_i,
  input  logic [4*NUM_PLAYERS-1:0] tens_i,
  input  logic [4*NUM_PLAYERS-1:0] ones_i,
  input  logic [NUM_PLAYERS-1:0]   enable_i,
  input  logic                     hold_i,
  input  logic                     sel_valid_i,
  input  logic [PW-1:0]            sel_player_i,
  output logic [3:0]               tens_o,
  output logic [3:0]               ones_o,
  output logic [PW-1:0]            player_o,
  output logic                     blinking_o
);

  localparam int SW       = $clog2(2 * BLINK_ON_PHASES);
  localparam int SUB_LAST = 2 * BLINK_ON_PHASES - 2;

  localparam logic [3:0] DIGIT_OFF = 4'd10;
  localparam logic [3:0] DIGIT_P   = 4'd11;

  typedef enum logic [1:0] {BLINK, SHOW, IDLE} state_t;

  state_t        state;
  logic [PW-1:0] player;
  logic [SW-1:0] sub;
  logic [TW-1:0] timer;

  // Enable mask padded to the full index space so out-of-range selects and
  // indexes read as disabled.
  logic [(1<<PW)-1:0] en_pad;
  logic [PW-1:0]      nxt;
  logic [PW-1:0]      low;
  logic               sel_ok;
  logic [3:0]         cur_t, cur_o;

  always_comb begin
    en_pad = '0;
    en_pad[NUM_PLAYERS-1:0] = enable_i;
  end

  assign sel_ok = sel_valid_i && en_pad[sel_player_i];

  // Next enabled player after the current one, wrapping; scanning offsets
  // from farthest to nearest lets the nearest hit win. Falls back to the
  // current player when nobody else is enabled.
  always_comb begin
    int idx;
    idx = 0;
    nxt = player;
    for (int i = NUM_PLAYERS - 1; i >= 1; i--) begin
      idx = (int'(player) + i) % NUM_PLAYERS;
      if (enable_i[idx]) nxt = PW'(idx);
    end
  end

  // Lowest enabled index, used when leaving IDLE.
  always_comb begin
    low = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (enable_i[i]) low = PW'(i);
  end

  // Current player's live score digits.
  always_comb begin
    cur_t = '0;
    cur_o = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (player == PW'(k)) begin
        cur_t = tens_i[4*k +: 4];
        cur_o = ones_i[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      state  <= BLINK;
      player <= '0;
      sub    <= '0;
      timer  <= '0;
    end else if (enable_i == '0) begin
      state <= IDLE;
      sub   <= '0;
      timer <= '0;
    end else if (state == IDLE) begin
      state  <= BLINK;
      player <= low;
      sub    <= '0;
      timer  <= '0;
    end else if (sel_ok) begin
      state  <= BLINK;
      player <= sel_player_i;
      sub    <= '0;
      timer  <= '0;
    end else if (!en_pad[player]) begin
      state  <= BLINK;
      player <= nxt;
      sub    <= '0;
      timer  <= '0;
    end else if (!hold_i) begin
      case (state)
        BLINK: begin
          if (timer == TW'(BLINK_MS - 1)) begin
            timer <= '0;
            if (sub < SW'(SUB_LAST)) begin
              sub <= sub + 1'b1;
            end else begin
              state <= SHOW;
              sub   <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SHOW: begin
          if (timer == TW'(DISPLAY_MS - 1)) begin
            state  <= BLINK;
            player <= nxt;
            sub    <= '0;
            timer  <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registers only, except SHOW which passes the live
  // score through (blanking anything that is not a numeral).
  always_comb begin
    tens_o     = DIGIT_OFF;
    ones_o     = DIGIT_OFF;
    blinking_o = 1'b0;
    case (state)
      BLINK: begin
        blinking_o = 1'b1;
        if (!sub[0]) begin
          tens_o = DIGIT_P;
          ones_o = {{(4-PW){1'b0}}, player} + 4'd1;
        end
      end
      SHOW: begin
        tens_o = (cur_t > 4'd9) ? DIGIT_OFF : cur_t;
        ones_o = (cur_o > 4'd9) ? DIGIT_OFF : cur_o;
      end
      default: ;
    endcase
  end

  assign player_o = player;

endmodule

// File: tb/tb_scoreboard_display_sequencer.sv
module tb_scoreboard_display_sequencer;
  localparam int N   = 3;
  localparam int BMS = 4;
  localparam int DMS = 8;
  localparam int BOP = 3;
  localparam int BLINK_LEN = (2*BOP - 1) * BMS;
  localparam int SEQ_LEN   = BLINK_LEN + DMS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [11:0]  tens_in, ones_in;
  logic [2:0]   en;
  logic         hold, sel_valid;
  logic [1:0]   sel_player;
  logic [3:0]   tens_o, ones_o;
  logic [1:0]   player_o;
  logic         blinking_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run    = 0;

  always #5 clk = ~clk;

  scoreboard_display_sequencer #(
    .NUM_PLAYERS(N), .BLINK_MS(BMS), .DISPLAY_MS(DMS), .BLINK_ON_PHASES(BOP)
  ) dut (
    .clk_1khz(clk), .rst_i(rst), .tens_i(tens_in), .ones_i(ones_in),
    .enable_i(en), .hold_i(hold), .sel_valid_i(sel_valid),
    .sel_player_i(sel_player), .tens_o(tens_o), .ones_o(ones_o),
    .player_o(player_o), .blinking_o(blinking_o)
  );

  // Model: each player's turn is an elapsed-cycle count 0..SEQ_LEN-1; the
  // first BLINK_LEN cycles are blink intervals, the rest is the score.
  bit m_idle;
  int m_player;
  int m_el;

  function automatic int lowest(logic [2:0] e);
    for (int i = 0; i < N; i++) if (e[i]) return i;
    return 0;
  endfunction

  function automatic int next_en(int p, logic [2:0] e);
    for (int k = 1; k < N; k++) if (e[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction

  function automatic logic [3:0] blank(logic [3:0] d);
    return (d > 9) ? 4'd10 : d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 0; m_player = 0; m_el = 0;
    end else if (en == 0) begin
      m_idle = 1;
    end else if (m_idle) begin
      m_idle = 0; m_player = lowest(en); m_el = 0;
    end else if (sel_valid && sel_player < N && en[sel_player]) begin
      m_player = int'(sel_player); m_el = 0;
    end else if (!en[m_player]) begin
      m_player = next_en(m_player, en); m_el = 0;
    end else if (!hold) begin
      m_el++;
      if (m_el == SEQ_LEN) begin
        m_el = 0;
        m_player = next_en(m_player, en);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] et, eo;
    logic eb;
    if (run && !rst) begin
      if (m_idle) begin
        et = 10; eo = 10; eb = 0;
      end else if (m_el < BLINK_LEN) begin
        eb = 1;
        if ((m_el / BMS) % 2 == 1) begin et = 10; eo = 10; end
        else begin et = 11; eo = 4'(m_player + 1); end
      end else begin
        eb = 0;
        et = blank(tens_in[4*m_player +: 4]);
        eo = blank(ones_in[4*m_player +: 4]);
      end
      checks++;
      if (tens_o !== et || ones_o !== eo || int'(player_o) != m_player || blinking_o !== eb) begin
        errors++;
        $display("FAIL model cyc%0d: got %0d/%0d p%0d b%0d, want %0d/%0d p%0d b%0d",
                 cyc, tens_o, ones_o, player_o, blinking_o, et, eo, m_player, eb);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic goto(int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0; cyc = 0; run = 1;
  endtask

  task automatic chk(string nm, logic [3:0] t, logic [3:0] o, int p, logic b);
    #1;
    checks++;
    if (tens_o !== t || ones_o !== o || int'(player_o) != p || blinking_o !== b) begin
      errors++;
      $display("FAIL %s: got %0d/%0d p%0d b%0d, want %0d/%0d p%0d b%0d",
               nm, tens_o, ones_o, player_o, blinking_o, t, o, p, b);
    end
  endtask

  task automatic defaults();
    tens_in = {4'd5, 4'd3, 4'd1};
    ones_in = {4'd6, 4'd4, 4'd2};
    en = 3'b111; hold = 0; sel_valid = 0; sel_player = 0;
  endtask

  initial begin
    defaults();
    // Basic rotation
    do_reset();
    chk("reset", 11, 1, 0, 1);
    goto(4);  chk("blank1", 10, 10, 0, 1);
    goto(8);  chk("on2", 11, 1, 0, 1);
    goto(12); chk("blank2", 10, 10, 0, 1);
    goto(19); chk("on3_end", 11, 1, 0, 1);
    goto(20); chk("show_p0", 1, 2, 0, 0);
    goto(27); chk("show_p0_end", 1, 2, 0, 0);
    goto(28); chk("p1_tag", 11, 2, 1, 1);
    goto(76); chk("show_p2", 5, 6, 2, 0);
    goto(84); chk("wrap_p0", 11, 1, 0, 1);

    // Enable mask skips player 1
    en = 3'b101;
    do_reset();
    goto(28); chk("mask_skip", 11, 3, 2, 1);
    goto(56); chk("mask_wrap", 11, 1, 0, 1);

    // Hold during SHOW with live score change
    defaults();
    do_reset();
    goto(22); hold = 1;
    goto(24); ones_in[3:0] = 4'd7; chk("hold_live", 1, 7, 0, 0);
    goto(32); hold = 0;
    goto(37); chk("hold_end", 1, 7, 0, 0);
    goto(38); chk("hold_next", 11, 2, 1, 1);

    // Jump to player 2
    defaults();
    do_reset();
    goto(10); sel_valid = 1; sel_player = 2;
    tick(); sel_valid = 0;
    chk("jump", 11, 3, 2, 1);
    goto(15); chk("jump_sub", 10, 10, 2, 1);

    // Out-of-range and disabled selects are ignored
    do_reset();
    goto(5); sel_valid = 1; sel_player = 3;
    tick(); sel_valid = 0;
    chk("sel_oor", 10, 10, 0, 1);
    en = 3'b101;
    goto(8); sel_valid = 1; sel_player = 1;
    tick(); sel_valid = 0;
    chk("sel_dis", 11, 1, 0, 1);

    // Disable all, then only player 1
    defaults();
    do_reset();
    goto(22); en = 3'b000;
    tick(); chk("idle", 10, 10, 0, 0);
    en = 3'b010;
    tick(); chk("idle_exit", 11, 2, 1, 1);
    goto(30);

    // Reset during SHOW
    defaults();
    do_reset();
    goto(22);
    do_reset();
    chk("reset_mid", 11, 1, 0, 1);

    // Non-numeral digit blanks during SHOW
    goto(22); tens_in[3:0] = 4'd12;
    chk("blanking", 10, 2, 0, 0);
    goto(26);

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scoreboard_display_sequencer.md
Name: scoreboard_display_sequencer

Overview:
- Time-multiplexes the scores of N players onto one two-digit display; generalises the fixed two-player controller.
- Per player: the tag "P<n>" blinks a configurable number of times, then that player's score is held, then the block advances to the next enabled player.
- Adds a per-player enable mask, a hold/freeze input and a direct jump to a chosen player.
- Sits between the score counters and the two BCD-to-7-segment digit decoders, and runs on the 1 kHz tick clock.

Parameters:
- NUM_PLAYERS, 2, number of score channels; legal range 2..8.
- BLINK_MS, 500, length of each blink on/off interval, in clk_1khz cycles; must be ≥1.
- DISPLAY_MS, 2000, length of the score-display interval, in cycles; must be ≥1.
- BLINK_ON_PHASES, 3, number of "on" intervals per blink phase; must be ≥1.
- Derived locals: PW = max(1, clog2(NUM_PLAYERS)); TW = clog2(max(BLINK_MS, DISPLAY_MS)+1).

Ports:
- clk_1khz  in  1  1 kHz clock.
- rst_i  in  1  reset. The clock is clk_1khz and a single clock is used. Reset rst_i is synchronous and active-high.
- tens_i  in  4*NUM_PLAYERS  packed tens digits; player k occupies [4k+3:4k].
- ones_i  in  4*NUM_PLAYERS  packed ones digits, same packing.
- enable_i  in  NUM_PLAYERS  bit k=1 includes player k in the rotation.
- hold_i  in  1  level input; freezes timer and sequence while high.
- sel_valid_i  in  1  single-cycle request to jump to sel_player_i.
- sel_player_i  in  PW  target player index.
- tens_o  out  4  tens digit code to the decoder.
- ones_o  out  4  ones digit code to the decoder.
- player_o  out  PW  index of the current player.
- blinking_o  out  1  1 while in BLINK state.

Behaviour:
- Digit codes: 0-9 = numerals, 10 = DIGIT_OFF (blank), 11 = DIGIT_P ('P').
- State registers: state {BLINK, SHOW, IDLE}, player, sub (blink interval index 0..2*BLINK_ON_PHASES-2), timer (TW bits).
- Outputs are a combinational decode of these registers only. Exception: in SHOW, tens_i/ones_i of the current player pass through live.
- Reset: state=BLINK, player=0, sub=0, timer=0.
  - Resulting outputs: tens_o=11, ones_o=1, player_o=0, blinking_o=1.
  - Reset mid-sequence aborts immediately.
- BLINK state:
  - Interval length = BLINK_MS cycles; timer counts 0..BLINK_MS-1.
  - sub even: tens_o=11, ones_o=player+1. sub odd: both outputs = 10.
  - At timer==BLINK_MS-1: timer←0. If sub<2*BLINK_ON_PHASES-2, sub←sub+1; otherwise state←SHOW, sub←0.
- SHOW state:
  - Timer counts 0..DISPLAY_MS-1.
  - Output is the current player's tens/ones digit; any input digit >9 is output as 10.
  - At timer==DISPLAY_MS-1: player←next enabled, state←BLINK, sub←0, timer←0.
- Next enabled player: first index with enable_i set, searching player+1, player+2, … with wrap modulo NUM_PLAYERS. If only the current player is enabled, it is selected again.
- IDLE state:
  - Entered from BLINK or SHOW when enable_i==0 (all bits clear). Outputs 10/10; player holds its value; blinking_o=0.
  - Leaves when any enable bit is set: next cycle state=BLINK, player=lowest set index, sub=0, timer=0.
- Current player disabled (enable_i[player]=0 while others remain set): next cycle player←next enabled, state=BLINK, sub=0, timer=0.
- hold_i=1: timer, sub, state and player are frozen and outputs remain static. SHOW continues to track live score inputs.
- sel_valid_i=1, with sel_player_i<NUM_PLAYERS and enable_i[sel_player_i]=1:
  - Next cycle player=sel_player_i, state=BLINK, sub=0, timer=0.
  - Applies even if already on that player. Otherwise the request is ignored.
- Priority per cycle: rst_i > all-disabled (IDLE) > valid sel > current-player-disabled > hold_i > normal timer advance.
- Full sequence length per player: (2*BLINK_ON_PHASES-1)*BLINK_MS + DISPLAY_MS cycles.

Test Plan:
- Test configuration: NUM_PLAYERS=3, BLINK_MS=4, DISPLAY_MS=8, BLINK_ON_PHASES=3, enable_i=3'b111, tens_i/ones_i = P0=12, P1=34, P2=56. Reset released at cycle 0.
- Basic sequence:
  - Cycles 0-3: outputs 11/1.
  - Cycles 4-7: 10/10. Cycles 8-11: 11/1. Cycles 12-15: 10/10. Cycles 16-19: 11/1.
  - Cycles 20-27: outputs 1/2.
  - Cycle 28: outputs 11/2, player_o=1.
  - P2's score 5/6 is shown in cycles 76-83; P0 blink restarts at cycle 84.
- Enable mask: enable_i=3'b101 from reset → after P0's SHOW, player_o jumps to 2 (outputs 11/3). After P2's SHOW, the sequence wraps to player_o=0.
- Hold: hold_i=1 for 10 cycles starting at cycle 22 → 1/2 is held through cycle 37; the P1 blink begins at cycle 38. Changing ones_i[3:0] to 7 during the hold makes ones_o=7 immediately.
- Jump: sel_valid_i=1 with sel_player_i=2 at cycle 10 → cycle 11 shows 11/3, blinking_o=1, and the sub counter restarts.
- Invalid jump: sel_player_i=3, or a select of a disabled player, is ignored.
- Disable: enable_i→0 during SHOW → next cycle 10/10, blinking_o=0. enable_i→3'b010 → next cycle 11/2, player_o=1.
- Reset mid-SHOW → next cycle 11/1, player_o=0.
- Blanking: an input digit of 12 during SHOW is displayed as 10.
